// File: rtl/mil1553_word_tx.sv
// MIL-STD-1553B word transmitter: sync, 16 data bits MSB first and odd parity,
// Manchester-II encoded onto the differential tx_pos/tx_neg pair.
module mil1553_word_tx #(
    parameter int unsigned CLKS_PER_HALF = 8,
    parameter int unsigned CNT_W         = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tx_valid,
    output logic        tx_ready,
    input  logic [15:0] tx_data,
    input  logic        tx_cmd,
    output logic        tx_pos,
    output logic        tx_neg,
    output logic        tx_busy,
    output logic        tx_done
);

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        DATA,
        PARITY
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_HALF - 1);
    localparam logic [CNT_W-1:0] CNT_PEN  = CNT_W'(CLKS_PER_HALF - 2);

    state_t           state;
    state_t           nxt_state;
    logic [CNT_W-1:0] cnt;
    logic [4:0]       hidx;
    logic [4:0]       nxt_hidx;
    logic [4:0]       bit_sel;
    logic [16:0]      bits_q;
    logic             cmd_q;
    logic             half_end;
    logic             word_end;
    logic             last_cycle_next;
    logic             nxt_level;

    assign half_end        = (cnt == CNT_LAST);
    assign word_end        = (state == PARITY) && (hidx == 5'd1) && half_end;
    assign last_cycle_next = (state == PARITY) && (hidx == 5'd1) && (cnt == CNT_PEN);

    // Half-bit sequencing: hidx counts half bits within the current state.
    always_comb begin
        nxt_state = state;
        nxt_hidx  = hidx + 5'd1;
        case (state)
            SYNC: begin
                if (hidx == 5'd5) begin
                    nxt_state = DATA;
                    nxt_hidx  = '0;
                end
            end
            DATA: begin
                if (hidx == 5'd31) begin
                    nxt_state = PARITY;
                    nxt_hidx  = '0;
                end
            end
            default: ;
        endcase
    end

    // bits_q holds data MSB at [16] down to parity at [0]; first half of a bit
    // carries the bit value, second half its complement.
    always_comb begin
        bit_sel   = '0;
        nxt_level = 1'b0;
        if (nxt_state == SYNC) begin
            nxt_level = (nxt_hidx < 5'd3) ? cmd_q : ~cmd_q;
        end else begin
            if (nxt_state == DATA) begin
                bit_sel = 5'd16 - {1'b0, nxt_hidx[4:1]};
            end
            nxt_level = bits_q[bit_sel] ^ nxt_hidx[0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            hidx     <= '0;
            bits_q   <= '0;
            cmd_q    <= 1'b0;
            tx_pos   <= 1'b0;
            tx_neg   <= 1'b0;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
            tx_ready <= 1'b1;
        end else begin
            tx_done <= 1'b0;
            // tx_ready is only high in IDLE or on the final parity cycle,
            // so this one branch covers both fresh and back-to-back starts.
            if (tx_valid && tx_ready) begin
                state    <= SYNC;
                cnt      <= '0;
                hidx     <= '0;
                bits_q   <= {tx_data, ~^tx_data};
                cmd_q    <= tx_cmd;
                tx_pos   <= tx_cmd;
                tx_neg   <= ~tx_cmd;
                tx_busy  <= 1'b1;
                tx_ready <= 1'b0;
            end else if (state != IDLE) begin
                if (word_end) begin
                    state   <= IDLE;
                    cnt     <= '0;
                    hidx    <= '0;
                    tx_pos  <= 1'b0;
                    tx_neg  <= 1'b0;
                    tx_busy <= 1'b0;
                end else if (half_end) begin
                    state  <= nxt_state;
                    hidx   <= nxt_hidx;
                    cnt    <= '0;
                    tx_pos <= nxt_level;
                    tx_neg <= ~nxt_level;
                end else begin
                    cnt <= cnt + 1'b1;
                    if (last_cycle_next) begin
                        tx_ready <= 1'b1;
                        tx_done  <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mil1553_word_tx.sv
// Self-checking bench for mil1553_word_tx: every cycle of each word is compared
// against a half-bit level table built from the 1553 word format.
module tb_mil1553_word_tx;

    localparam int CPH      = 8;
    localparam int WORD_CYC = 40 * CPH;

    logic        clk;
    logic        rst;
    logic        tx_valid;
    logic        tx_ready;
    logic [15:0] tx_data;
    logic        tx_cmd;
    logic        tx_pos;
    logic        tx_neg;
    logic        tx_busy;
    logic        tx_done;

    int checks   = 0;
    int failures = 0;
    logic mon_en = 1'b0;

    mil1553_word_tx #(
        .CLKS_PER_HALF(CPH),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .tx_data(tx_data),
        .tx_cmd(tx_cmd),
        .tx_pos(tx_pos),
        .tx_neg(tx_neg),
        .tx_busy(tx_busy),
        .tx_done(tx_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Line levels of the 40 half bits of a word, index 0 first; 1 means "+".
    function automatic logic [39:0] ref_levels(input logic [15:0] d, input logic c);
        logic [39:0] lv;
        int unsigned ones;
        logic p;
        lv   = '0;
        ones = 0;
        for (int i = 0; i < 3; i++) begin
            lv[i]     = c;
            lv[i + 3] = !c;
        end
        for (int i = 0; i < 16; i++) begin
            ones          += d[15 - i];
            lv[6 + 2 * i] = d[15 - i];
            lv[7 + 2 * i] = !d[15 - i];
        end
        p      = (ones % 2 == 0);
        lv[38] = p;
        lv[39] = !p;
        return lv;
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if ((tx_pos & tx_neg) !== 1'b0 ||
                $isunknown({tx_pos, tx_neg, tx_busy, tx_ready, tx_done})) begin
                failures++;
                $display("FAIL line_sanity t=%0t got pos=%b neg=%b busy=%b ready=%b done=%b required no overlap/no X",
                         $time, tx_pos, tx_neg, tx_busy, tx_ready, tx_done);
            end
        end
    end

    task automatic check_idle(input string name);
        logic [4:0] got;
        got = {tx_pos, tx_neg, tx_busy, tx_ready, tx_done};
        checks++;
        if (got !== 5'b00010) begin
            failures++;
            $display("FAIL %s t=%0t got {pos,neg,busy,ready,done}=%b required 00010", name, $time, got);
        end
    endtask

    // Waits until the block is ready, offers a word, and returns just after the accepting edge.
    task automatic offer(input logic [15:0] d, input logic c);
        int n;
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = d;
        tx_cmd   = c;
        n = 0;
        while (tx_ready !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 2000) begin
            failures++;
            $display("FAIL accept_timeout got tx_ready=%b required 1 within 2000 cycles", tx_ready);
        end
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        tx_data  = 16'($urandom);
        tx_cmd   = 1'($urandom);
    endtask

    // Checks all cycles of a word whose accept edge has just passed. If follow_at
    // is nonzero, the next word is offered from that cycle onward and must be
    // accepted at the end of this word.
    task automatic check_word(input logic [15:0] d, input logic c, input int follow_at,
                              input logic [15:0] nd, input logic nc);
        logic [39:0] lv;
        logic [4:0]  exp;
        logic [4:0]  got;
        lv = ref_levels(d, c);
        for (int k = 1; k <= WORD_CYC; k++) begin
            @(negedge clk);
            exp = {lv[(k - 1) / CPH], !lv[(k - 1) / CPH], 1'b1,
                   (k == WORD_CYC), (k == WORD_CYC)};
            got = {tx_pos, tx_neg, tx_busy, tx_ready, tx_done};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL word_cycle data=%h cmd=%b k=%0d got {pos,neg,busy,ready,done}=%b required %b",
                         d, c, k, got, exp);
            end
            if (follow_at != 0 && k == follow_at) begin
                tx_valid = 1'b1;
                tx_data  = nd;
                tx_cmd   = nc;
            end
        end
        if (follow_at != 0) begin
            @(posedge clk);
            #1;
            tx_valid = 1'b0;
            tx_data  = 16'($urandom);
            tx_cmd   = 1'($urandom);
        end else begin
            @(negedge clk);
            check_idle("post_word_idle");
        end
    endtask

    task automatic send_single(input logic [15:0] d, input logic c);
        offer(d, c);
        check_word(d, c, 0, '0, 1'b0);
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        tx_valid = 1'b0;
        tx_data  = '0;
        tx_cmd   = 1'b0;
        repeat (3) @(negedge clk);
        check_idle("reset_state");
        mon_en = 1'b1;
        rst    = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            check_idle("idle_hold");
        end
    endtask

    task automatic test_cmd_word();
        send_single(16'h0000, 1'b1);
    endtask

    task automatic test_data_word();
        send_single(16'h0001, 1'b0);
        send_single(16'hFFFF, 1'b0);
        send_single(16'h8000, 1'b0);
        send_single(16'hA5C3, 1'b1);
    endtask

    task automatic test_back_to_back();
        logic [15:0] d [0:2];
        logic        c [0:2];
        for (int i = 0; i < 3; i++) begin
            d[i] = 16'($urandom);
            c[i] = 1'($urandom);
        end
        offer(d[0], c[0]);
        check_word(d[0], c[0], WORD_CYC, d[1], c[1]);
        check_word(d[1], c[1], WORD_CYC, d[2], c[2]);
        check_word(d[2], c[2], 0, '0, 1'b0);
    endtask

    task automatic test_valid_during_data();
        logic [15:0] d0;
        logic [15:0] d1;
        logic        c0;
        logic        c1;
        int          at;
        d0 = 16'($urandom);
        d1 = 16'($urandom);
        c0 = 1'($urandom);
        c1 = 1'($urandom);
        at = int'($urandom_range(60, 290));
        offer(d0, c0);
        check_word(d0, c0, at, d1, c1);
        check_word(d1, c1, 0, '0, 1'b0);
    endtask

    task automatic test_reset_mid_data();
        logic [15:0] d;
        logic        c;
        int          stop;
        d    = 16'($urandom);
        c    = 1'($urandom);
        stop = int'($urandom_range(60, 290));
        offer(d, c);
        repeat (stop) @(negedge clk);
        checks++;
        if (tx_busy !== 1'b1) begin
            failures++;
            $display("FAIL busy_before_abort got %b required 1", tx_busy);
        end
        rst = 1'b1;
        @(negedge clk);
        check_idle("abort_idle");
        @(negedge clk);
        check_idle("abort_hold");
        rst = 1'b0;
        @(negedge clk);
        check_idle("abort_release");
        d = 16'($urandom);
        c = 1'($urandom);
        send_single(d, c);
    endtask

    task automatic test_random_words();
        logic [15:0] d;
        logic [15:0] nd;
        logic        c;
        logic        nc;
        int          at;
        d = 16'($urandom);
        c = 1'($urandom);
        offer(d, c);
        for (int i = 0; i < 5; i++) begin
            nd = 16'($urandom);
            nc = 1'($urandom);
            at = ($urandom_range(0, 1) == 0) ? WORD_CYC : int'($urandom_range(1, WORD_CYC));
            check_word(d, c, at, nd, nc);
            d = nd;
            c = nc;
        end
        check_word(d, c, 0, '0, 1'b0);
    endtask

    initial begin
        rst      = 1'b1;
        tx_valid = 1'b0;
        tx_data  = '0;
        tx_cmd   = 1'b0;
        test_reset();
        test_cmd_word();
        test_data_word();
        test_back_to_back();
        test_valid_during_data();
        test_reset_mid_data();
        test_random_words();
        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
